mig_app_responder: RTL and testbench
====================================

Name: mig_app_responder

Overview:
- Synthesizable responder model of the MIG 7-series user (app_*) interface, driven by our app-interface initiator state machines.
- Replaces mig_7series_0 in simulation and in on-chip loopback builds.
- Answers write/read commands from a small internal memory, with calibration delay, injectable back-pressure and a fixed read latency.
- Lets the initiator FSMs be verified without the DDR3 PHY.

Parameters:
- ADDR_W, 29, app_addr width
- DATA_W, 256, app data width
- MASK_W, 32, byte-mask width (DATA_W/8)
- DEPTH_LOG2, 8, log2 of memory depth in DATA_W words
- RD_LAT, 4, cycles from read-command acceptance to app_rd_data_valid (≥1)
- CALIB_CYCLES, 16, cycles after reset release before init_calib_complete
- WDF_DEPTH, 4, write-data FIFO entries (power of 2)

Ports:
- ui_clk  in  1  clock
- ui_clk_sync_rst  in  1  reset, asynchronous, active-high
- app_addr  in  ADDR_W  command address, steps by 8 per DATA_W word
- app_cmd  in  3  3'b000 write, 3'b001 read
- app_en  in  1  command valid
- app_wdf_data  in  DATA_W  write data
- app_wdf_wren  in  1  write data valid
- app_wdf_end  in  1  last beat; ignored, BL8 single beat
- app_wdf_mask  in  MASK_W  1 = byte not written
- stall_inject  in  1  forces app_rdy low while high
- app_rdy  out  1  command accepted when app_en & app_rdy
- app_wdf_rdy  out  1  write data accepted when app_wdf_wren & app_wdf_rdy
- app_rd_data  out  DATA_W  read data
- app_rd_data_valid  out  1  read data strobe
- app_rd_data_end  out  1  equals app_rd_data_valid
- init_calib_complete  out  1  calibration done
- cmd_err  out  1  sticky: illegal cmd accepted

Behaviour:
- Reset (async, immediate) values: app_rdy=0, app_wdf_rdy=0, app_rd_data_valid=0, app_rd_data_end=0, app_rd_data=0, init_calib_complete=0, cmd_err=0.
- Reset also clears the FIFO pointers, pending-write flag and read pipeline. Memory contents are NOT reset.
- FSM states:
  - CALIB: counts CALIB_CYCLES. The count starts at the first ui_clk edge after reset deasserts. At count end, init_calib_complete goes to 1 and the FSM moves to RUN.
  - RUN: serves commands.
  - WAIT_WDATA: a write command has been accepted but the FIFO is empty. Returns to RUN in the cycle the data is consumed.
- Reset in any state returns the FSM to CALIB.
- app_wdf_rdy = (state != CALIB) & FIFO not full.
- Write data may arrive before, with, or after its command. Data presented in the same cycle as its command bypasses the FIFO.
- app_rdy = (state == RUN) & ~stall_inject. It is combinational from state and stall_inject only, never from app_en.
- Word index = app_addr[DEPTH_LOG2+2:3].
  - app_addr[2:0] is ignored.
  - Upper address bits alias (wrap modulo depth).
- Write accepted in RUN:
  - If data is available (FIFO head or bypass), the memory word is updated that cycle, per byte: byte i is written iff mask[i]=0.
  - Otherwise the address and mask-less write are held in a pending register and the FSM enters WAIT_WDATA (app_rdy=0).
  - The write commits, using the data's mask, in the first cycle app_wdf_wren & app_wdf_rdy occurs.
- Read accepted:
  - The word is read at acceptance, after any write committing in the same cycle. Read-after-write in back-to-back cycles returns the new data.
  - The word enters an RD_LAT-deep valid/data shift pipeline. Data appears RD_LAT cycles after the accepting edge, in command order, with no bubbles required.
- Any other app_cmd value is accepted with no memory effect and sets cmd_err=1 until reset.
- Full FIFO: app_wdf_rdy=0; a wren presented then is not taken.
- Simultaneous FIFO push and pop in one cycle is allowed at any fill level except: a push when full is blocked.
- stall_inject during WAIT_WDATA has no effect on completion of the pending write.
- Read responses already in the pipeline complete regardless of stall_inject or app_en.

Decomposition:
- Shared package mig_app_pkg holds:
  - CMD_WRITE=3'b000 and CMD_READ=3'b001, also used by the initiator FSMs.
  - State enum.
  - Width localparams.
- Sub-module mig_wdf_fifo: synchronous FIFO with WDF_DEPTH entries, DATA_W+MASK_W wide, with full/empty/push/pop, on the same clock and reset.
- Memory array and read pipeline stay in the top module.

Test Plan:
- Reset release: init_calib_complete rises exactly 16 cycles after reset deassert. app_rdy and app_wdf_rdy stay 0 until then.
- Write then read:
  - Write addresses 0,8,…,72 with data 2,4,…,20, mask 0.
  - Read the same addresses back-to-back → 10 valid beats returning 2…20 in order, first beat 4 cycles after the first read acceptance.
- Masked write:
  - Write 0xFF..FF to addr 16, then data 0 with mask 32'hFFFF_FFFE.
  - Read addr 16 → byte0=0x00, all other bytes 0xFF.
- Late write data:
  - Issue write cmd to addr 8 with no wren → app_rdy=0 (WAIT_WDATA).
  - Supply data 0x55 three cycles later → app_rdy returns 1. Read addr 8 → 0x55.
- Back-pressure and FIFO full:
  - Push 4 wren beats with no commands → app_wdf_rdy drops after the 4th.
  - Toggle stall_inject → app_rdy follows ~stall_inject. No command is accepted while it is high.
- Illegal cmd and reset mid-read:
  - app_cmd=3'b011 accepted → cmd_err=1, memory unchanged.
  - Assert reset with 2 reads in flight → app_rd_data_valid=0 immediately and cmd_err=0. No stale beats after recalibration.

Source files
------------

// File: rtl/mig_app_responder_pkg.sv
// mig_app_pkg: shared definitions for the MIG app-interface responder and the
// app-interface initiator FSMs that drive it.
//   - app_cmd encodings (CMD_WRITE / CMD_READ)
//   - responder FSM state enum
//   - default app-interface widths
package mig_app_pkg;

    localparam int APP_ADDR_W = 29;
    localparam int APP_DATA_W = 256;
    localparam int APP_MASK_W = APP_DATA_W / 8;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_CALIB      = 2'd0,
        ST_RUN        = 2'd1,
        ST_WAIT_WDATA = 2'd2
    } state_e;

endpackage

// File: rtl/mig_app_responder_if.sv
// mig_app_if: MIG 7-series user (app_*) interface bundle.
//   master  : initiator side (drives command, write data, stall_inject)
//   slave   : responder side (drives ready, read data, calibration, cmd_err)
// Clock and reset stay outside the bundle as plain ports.
interface mig_app_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 256,
    parameter int MASK_W = DATA_W / 8
);
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [MASK_W-1:0] app_wdf_mask;
    logic              stall_inject;
    logic              app_rdy;
    logic              app_wdf_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;
    logic              app_rd_data_end;
    logic              init_calib_complete;
    logic              cmd_err;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
               app_wdf_end, app_wdf_mask, stall_inject,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end, init_calib_complete, cmd_err
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
               app_wdf_end, app_wdf_mask, stall_inject,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end, init_calib_complete, cmd_err
    );
endinterface

// File: rtl/mig_app_responder_wdf_fifo.sv
// mig_wdf_fifo: synchronous write-data FIFO holding {mask, data} entries.
// Ports:
//   ui_clk, ui_clk_sync_rst : clock, async active-high reset (clears pointers)
//   push_i, din_i           : write side; a push while full is dropped
//   pop_i, dout_o           : read side; dout_o shows the head entry
//   full_o, empty_o         : occupancy flags
module mig_wdf_fifo #(
    parameter int WIDTH = 288,
    parameter int DEPTH = 4
) (
    input  logic             ui_clk,
    input  logic             ui_clk_sync_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: storage arrays carry no reset; only the pointers define validity.
    always_ff @(posedge ui_clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/mig_app_responder.sv
// mig_app_responder: synthesizable stand-in for mig_7series_0 on the app_*
// interface. Serves write/read commands from a small internal memory after a
// calibration delay, with injectable back-pressure and fixed read latency.
// Ports:
//   ui_clk, ui_clk_sync_rst : clock, async active-high reset
//   app (mig_app_if.slave)  : command, write-data, read-data, calibration,
//                             stall_inject and sticky cmd_err
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int ADDR_W       = APP_ADDR_W,
    parameter int DATA_W       = APP_DATA_W,
    parameter int MASK_W       = APP_MASK_W,
    parameter int DEPTH_LOG2   = 8,
    parameter int RD_LAT       = 4,
    parameter int CALIB_CYCLES = 16,
    parameter int WDF_DEPTH    = 4
) (
    input  logic     ui_clk,
    input  logic     ui_clk_sync_rst,
    mig_app_if.slave app
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(CALIB_CYCLES + 1);
    localparam int ENT_W = DATA_W + MASK_W;

    state_e                state_q;
    logic [CNT_W-1:0]      calib_cnt_q;
    logic                  calib_done_q;
    logic [DEPTH_LOG2-1:0] pend_idx_q;
    logic                  cmd_err_q;
    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [RD_LAT-1:0]     rd_vld_q;
    logic [DATA_W-1:0]     rd_dat_q [RD_LAT];

    logic                  cmd_fire, is_wr, is_rd, wdf_fire, wr_cmd, go_wait;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]      fifo_dout;
    logic [DEPTH_LOG2-1:0] cmd_idx;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic [DATA_W-1:0]     mem_wdata;
    logic [MASK_W-1:0]     mem_wmask;
    logic                  unused_ok;

    // Command address steps by 8 per word; low bits and upper bits are dropped.
    assign cmd_idx   = app.app_addr[DEPTH_LOG2+2:3];
    assign unused_ok = ^{app.app_wdf_end, app.app_addr[2:0],
                         app.app_addr[ADDR_W-1:DEPTH_LOG2+3]};

    assign app.app_rdy     = (state_q == ST_RUN) && !app.stall_inject;
    assign app.app_wdf_rdy = (state_q != ST_CALIB) && !fifo_full;

    assign cmd_fire = app.app_en && app.app_rdy;
    assign is_wr    = (app.app_cmd == CMD_WRITE);
    assign is_rd    = (app.app_cmd == CMD_READ);
    assign wdf_fire = app.app_wdf_wren && app.app_wdf_rdy;
    assign wr_cmd   = cmd_fire && is_wr;
    assign go_wait  = wr_cmd && fifo_empty && !wdf_fire;

    // Queued data is older than same-cycle data, so a write command takes the
    // FIFO head if one exists; same-cycle data on an empty FIFO bypasses it.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fifo_pop  = 1'b0;
        fifo_push = wdf_fire;
        mem_we    = 1'b0;
        mem_widx  = cmd_idx;
        mem_wdata = app.app_wdf_data;
        mem_wmask = app.app_wdf_mask;
        if (state_q == ST_WAIT_WDATA) begin
            fifo_push = 1'b0;
            mem_we    = wdf_fire;
            mem_widx  = pend_idx_q;
        end else if (wr_cmd) begin
            if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = fifo_dout[DATA_W-1:0];
                mem_wmask = fifo_dout[ENT_W-1:DATA_W];
            end else if (wdf_fire) begin
                fifo_push = 1'b0;
                mem_we    = 1'b1;
            end
        end
    end

    mig_wdf_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (WDF_DEPTH)
    ) u_wdf_fifo (
        .ui_clk          (ui_clk),
        .ui_clk_sync_rst (ui_clk_sync_rst),
        .push_i          (fifo_push),
        .din_i           ({app.app_wdf_mask, app.app_wdf_data}),
        .pop_i           (fifo_pop),
        .dout_o          (fifo_dout),
        .full_o          (fifo_full),
        .empty_o         (fifo_empty)
    );

    // Mask bit set means the byte is left untouched.
    always_ff @(posedge ui_clk) begin
        if (mem_we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (!mem_wmask[i]) mem_q[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            state_q      <= ST_CALIB;
            calib_cnt_q  <= '0;
            calib_done_q <= 1'b0;
            pend_idx_q   <= '0;
            cmd_err_q    <= 1'b0;
        end else begin
            if (cmd_fire && !is_wr && !is_rd) cmd_err_q <= 1'b1;
            case (state_q)
                ST_CALIB: begin
                    if (calib_cnt_q == CNT_W'(CALIB_CYCLES - 1)) begin
                        state_q      <= ST_RUN;
                        calib_done_q <= 1'b1;
                    end else begin
                        calib_cnt_q <= calib_cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (go_wait) begin
                        state_q    <= ST_WAIT_WDATA;
                        pend_idx_q <= cmd_idx;
                    end
                end
                ST_WAIT_WDATA: begin
                    if (wdf_fire) state_q <= ST_RUN;
                end
                default: state_q <= ST_CALIB;
            endcase
        end
    end

    // Reads sample memory at acceptance; only one command fires per cycle and
    // pending writes commit only while app_rdy is low, so the word read always
    // reflects every earlier write.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            rd_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) rd_dat_q[i] <= '0;
        end else begin
            rd_vld_q[0] <= cmd_fire && is_rd;
            rd_dat_q[0] <= mem_q[cmd_idx];
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_dat_q[i] <= rd_dat_q[i-1];
            end
        end
    end

    assign app.app_rd_data         = rd_dat_q[RD_LAT-1];
    assign app.app_rd_data_valid   = rd_vld_q[RD_LAT-1];
    assign app.app_rd_data_end     = rd_vld_q[RD_LAT-1];
    assign app.init_calib_complete = calib_done_q;
    assign app.cmd_err             = cmd_err_q;
endmodule

// File: tb/tb_mig_app_responder.sv
module tb_mig_app_responder;
    import mig_app_pkg::*;

    localparam int RD_LAT = 4;
    localparam int CALIB  = 16;

    typedef struct {
        logic [255:0] data;
        int           due;
    } exp_t;

    logic ui_clk = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mig_app_if #(.ADDR_W(29), .DATA_W(256), .MASK_W(32)) app_bus ();

    mig_app_responder #(
        .ADDR_W(29), .DATA_W(256), .MASK_W(32), .DEPTH_LOG2(8),
        .RD_LAT(RD_LAT), .CALIB_CYCLES(CALIB), .WDF_DEPTH(4)
    ) dut (
        .ui_clk          (ui_clk),
        .ui_clk_sync_rst (rst),
        .app             (app_bus)
    );

    always #5 ui_clk = ~ui_clk;
    always @(posedge ui_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a read beat appears.
    always @(negedge ui_clk) begin
        if (!rst) begin
            if (app_bus.app_rd_data_valid) begin
                check("rd_end", {255'd0, app_bus.app_rd_data_end}, 256'd1);
                if (exp_q.size() == 0) begin
                    check("rd_unexpected_beat", app_bus.app_rd_data, 256'hx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rd_data", app_bus.app_rd_data, e.data);
                    check("rd_latency_cycle", 256'(cyc), 256'(e.due));
                end
            end else begin
                if (app_bus.app_rd_data_end)
                    check("rd_end_idle", 256'd1, 256'd0);
                if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rd_missing_beat", 256'd0, e.data);
                end
            end
        end
    end

    task automatic send(input logic [2:0] cmd, input logic [28:0] addr, input logic wren,
                        input logic [255:0] data, input logic [31:0] mask,
                        input logic [255:0] exp_rd);
        int tries = 0;
        @(negedge ui_clk);
        app_bus.app_cmd      = cmd;
        app_bus.app_addr     = addr;
        app_bus.app_en       = 1'b1;
        app_bus.app_wdf_wren = wren;
        app_bus.app_wdf_data = data;
        app_bus.app_wdf_mask = mask;
        app_bus.app_wdf_end  = wren;
        while (!app_bus.app_rdy && tries < 200) begin
            @(negedge ui_clk);
            tries++;
        end
        if (tries >= 200) check("cmd_accept_timeout", 256'd0, 256'd1);
        if (cmd == CMD_READ) exp_q.push_back('{exp_rd, cyc + RD_LAT});
        @(posedge ui_clk);
        #1;
        app_bus.app_en       = 1'b0;
        app_bus.app_wdf_wren = 1'b0;
        app_bus.app_wdf_end  = 1'b0;
    endtask

    task automatic wr(input logic [28:0] addr, input logic [255:0] data, input logic [31:0] mask);
        send(CMD_WRITE, addr, 1'b1, data, mask, '0);
    endtask

    task automatic rd(input logic [28:0] addr, input logic [255:0] exp);
        send(CMD_READ, addr, 1'b0, '0, '0, exp);
    endtask

    task automatic push_wdata(input logic [255:0] data);
        @(negedge ui_clk);
        app_bus.app_wdf_wren = 1'b1;
        app_bus.app_wdf_data = data;
        app_bus.app_wdf_mask = '0;
        @(posedge ui_clk);
        #1;
        app_bus.app_wdf_wren = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy"},      {255'd0, app_bus.app_rdy}, 256'd0);
        check({tag, "_wdf_rdy"},  {255'd0, app_bus.app_wdf_rdy}, 256'd0);
        check({tag, "_valid"},    {255'd0, app_bus.app_rd_data_valid}, 256'd0);
        check({tag, "_rd_data"},  app_bus.app_rd_data, 256'd0);
        check({tag, "_calib"},    {255'd0, app_bus.init_calib_complete}, 256'd0);
        check({tag, "_cmd_err"},  {255'd0, app_bus.cmd_err}, 256'd0);
    endtask

    task automatic calibrate();
        @(negedge ui_clk);
        rst = 1'b0;
        for (int i = 1; i <= CALIB; i++) begin
            @(posedge ui_clk);
            #1;
            check($sformatf("calib_edge%0d", i), {255'd0, app_bus.init_calib_complete},
                  (i == CALIB) ? 256'd1 : 256'd0);
            if (i >= CALIB - 1) begin
                check($sformatf("rdy_edge%0d", i), {255'd0, app_bus.app_rdy},
                      (i == CALIB) ? 256'd1 : 256'd0);
                check($sformatf("wdf_rdy_edge%0d", i), {255'd0, app_bus.app_wdf_rdy},
                      (i == CALIB) ? 256'd1 : 256'd0);
            end
        end
    endtask

    initial begin
        logic [255:0] masked_exp;
        masked_exp = {{31{8'hFF}}, 8'h00};
        app_bus.app_addr     = '0;
        app_bus.app_cmd      = '0;
        app_bus.app_en       = 1'b0;
        app_bus.app_wdf_data = '0;
        app_bus.app_wdf_wren = 1'b0;
        app_bus.app_wdf_end  = 1'b0;
        app_bus.app_wdf_mask = '0;
        app_bus.stall_inject = 1'b0;

        // Reset state and calibration timing
        #23;
        check_idle_outputs("reset");
        calibrate();

        // Write then read back-to-back
        for (int i = 0; i < 10; i++) wr(29'(8 * i), 256'(2 * (i + 1)), '0);
        for (int i = 0; i < 10; i++) rd(29'(8 * i), 256'(2 * (i + 1)));

        // Address aliasing and ignored low bits
        rd(29'(256 * 8), 256'd2);
        rd(29'd13, 256'd4);

        // Masked write: only byte 0 written
        wr(29'd16, '1, '0);
        wr(29'd16, '0, 32'hFFFF_FFFE);
        rd(29'd16, masked_exp);

        // Late write data
        send(CMD_WRITE, 29'd8, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge ui_clk);
            check("wait_wdata_rdy", {255'd0, app_bus.app_rdy}, 256'd0);
        end
        push_wdata(256'h55);
        check("wait_done_rdy", {255'd0, app_bus.app_rdy}, 256'd1);
        rd(29'd8, 256'h55);

        // FIFO fill with no commands
        for (int i = 0; i < 4; i++) begin
            push_wdata(256'hA1 + 256'(i));
            check($sformatf("wdf_rdy_after_push%0d", i + 1), {255'd0, app_bus.app_wdf_rdy},
                  (i == 3) ? 256'd0 : 256'd1);
        end
        push_wdata(256'hEE);
        check("wdf_rdy_still_full", {255'd0, app_bus.app_wdf_rdy}, 256'd0);
        for (int i = 0; i < 4; i++) send(CMD_WRITE, 29'(24 + 8 * i), 1'b0, '0, '0, '0);
        check("wdf_rdy_drained", {255'd0, app_bus.app_wdf_rdy}, 256'd1);
        for (int i = 0; i < 4; i++) rd(29'(24 + 8 * i), 256'hA1 + 256'(i));

        // Stall injection holds off a pending read
        @(negedge ui_clk);
        app_bus.stall_inject = 1'b1;
        app_bus.app_cmd      = CMD_READ;
        app_bus.app_addr     = 29'd0;
        app_bus.app_en       = 1'b1;
        #1;
        check("stall_rdy_low", {255'd0, app_bus.app_rdy}, 256'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge ui_clk);
            check("stall_rdy_held", {255'd0, app_bus.app_rdy}, 256'd0);
        end
        app_bus.stall_inject = 1'b0;
        #1;
        check("unstall_rdy_high", {255'd0, app_bus.app_rdy}, 256'd1);
        exp_q.push_back('{256'd2, cyc + RD_LAT});
        @(posedge ui_clk);
        #1;
        app_bus.app_en = 1'b0;

        // Illegal command: sticky error, memory untouched
        check("cmd_err_before", {255'd0, app_bus.cmd_err}, 256'd0);
        send(3'b011, 29'd0, 1'b0, '0, '0, '0);
        check("cmd_err_set", {255'd0, app_bus.cmd_err}, 256'd1);
        rd(29'd0, 256'd2);
        repeat (8) @(posedge ui_clk);
        check("cmd_err_sticky", {255'd0, app_bus.cmd_err}, 256'd1);

        // Reset with reads in flight
        rd(29'd8, 256'h55);
        rd(29'd16, masked_exp);
        @(posedge ui_clk);
        @(posedge ui_clk);
        #1;
        check("pre_reset_valid", {255'd0, app_bus.app_rd_data_valid}, 256'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(posedge ui_clk);
        calibrate();
        repeat (10) @(posedge ui_clk);
        rd(29'd8, 256'h55);

        begin
            int waited = 0;
            while (exp_q.size() > 0 && waited < 50) begin
                @(posedge ui_clk);
                waited++;
            end
            #1;
            check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
